// File: rtl/wb_buffer_if.sv
// Bus bundle for the writeback buffer: the producer/result side, the
// register bank write port and the decode-stage forwarding lookup.
interface wb_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
);
  localparam int CWIDTH = $clog2(DEPTH) + 1;

  // result input handshake
  logic              in_valid;
  logic              in_ready;
  logic [AWIDTH-1:0] in_addr;
  logic [DWIDTH-1:0] in_data;

  // register bank write port
  logic              wr_grant;
  logic              reg_write;
  logic [AWIDTH-1:0] aw;
  logic [DWIDTH-1:0] din;

  // forwarding lookup
  logic [AWIDTH-1:0] ar1;
  logic [AWIDTH-1:0] ar2;
  logic              hit1;
  logic              hit2;
  logic [DWIDTH-1:0] fwd1;
  logic [DWIDTH-1:0] fwd2;

  // occupancy
  logic [CWIDTH-1:0] count;

  // upstream producer / decode stage / bank arbiter side
  modport master (
    output in_valid, in_addr, in_data, wr_grant, ar1, ar2,
    input  in_ready, reg_write, aw, din, hit1, hit2, fwd1, fwd2, count
  );

  // the buffer itself
  modport slave (
    input  in_valid, in_addr, in_data, wr_grant, ar1, ar2,
    output in_ready, reg_write, aw, din, hit1, hit2, fwd1, fwd2, count
  );
endinterface

// File: rtl/wb_buffer.sv
// Writeback buffer in front of the register bank write port.
// Completed results are queued as (dest, data) pairs in a DEPTH-entry FIFO
// and drained one per granted cycle through a registered write port.
// Results not yet written are visible to decode through a combinational
// forwarding lookup that returns the youngest matching value.
module wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_buffer_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage and bookkeeping
  logic [AWIDTH-1:0] addr_mem_r [DEPTH];
  logic [DWIDTH-1:0] data_mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  // registered bank write port
  logic              reg_write_r;
  logic [AWIDTH-1:0] aw_r;
  logic [DWIDTH-1:0] din_r;

  // handshake decode
  logic              full_s;
  logic              ready_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;

  // forwarding results
  logic [DWIDTH:0]   look1_s;
  logic [DWIDTH:0]   look2_s;

  // Forwarding search, oldest to youngest so the last match wins:
  // the output register (being written this cycle) is older than every
  // queued entry, and queued entries age from the read pointer forward.
  // Register 0 is never forwarded.
  function automatic logic [DWIDTH:0] lookup(input logic [AWIDTH-1:0] ar);
    logic              hit;
    logic [DWIDTH-1:0] data;
    logic [PW-1:0]     idx;
    hit  = 1'b0;
    data = {DWIDTH{1'b0}};
    if (ar != {AWIDTH{1'b0}}) begin
      if (reg_write_r && (aw_r == ar)) begin
        hit  = 1'b1;
        data = din_r;
      end else begin
        hit  = 1'b0;
        data = {DWIDTH{1'b0}};
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_r + PW'(i);
        if ((CW'(i) < count_r) && (addr_mem_r[idx] == ar)) begin
          hit  = 1'b1;
          data = data_mem_r[idx];
        end else begin
          hit  = hit;
          data = data;
        end
      end
    end else begin
      hit  = 1'b0;
      data = {DWIDTH{1'b0}};
    end
    return {hit, data};
  endfunction

  // Handshake decode from registered state only; ready is held low while
  // reset is asserted so nothing is accepted until release.
  always_comb begin
    full_s   = (count_r == CW'(DEPTH));
    ready_s  = rst_n & ~full_s;
    accept_s = bus.in_valid & ready_s;
    push_s   = accept_s & (bus.in_addr != {AWIDTH{1'b0}});
    pop_s    = (count_r != {CW{1'b0}}) & bus.wr_grant;
  end

  // Pointer and occupancy update; simultaneous push and pop keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (!push_s && pop_s) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {AWIDTH{1'b0}};
        data_mem_r[i] <= {DWIDTH{1'b0}};
      end
    end else if (push_s) begin
      addr_mem_r[wr_ptr_r] <= bus.in_addr;
      data_mem_r[wr_ptr_r] <= bus.in_data;
    end
  end

  // Bank write port: one-cycle strobe per pop, address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_r <= 1'b0;
      aw_r        <= {AWIDTH{1'b0}};
      din_r       <= {DWIDTH{1'b0}};
    end else if (pop_s) begin
      reg_write_r <= 1'b1;
      aw_r        <= addr_mem_r[rd_ptr_r];
      din_r       <= data_mem_r[rd_ptr_r];
    end else begin
      reg_write_r <= 1'b0;
    end
  end

  // Forwarding lookups for both decode read ports.
  always_comb begin
    look1_s = lookup(bus.ar1);
    look2_s = lookup(bus.ar2);
  end

  assign bus.in_ready  = ready_s;
  assign bus.reg_write = reg_write_r;
  assign bus.aw        = aw_r;
  assign bus.din       = din_r;
  assign bus.count     = count_r;
  assign bus.hit1      = look1_s[DWIDTH];
  assign bus.fwd1      = look1_s[DWIDTH-1:0];
  assign bus.hit2      = look2_s[DWIDTH];
  assign bus.fwd2      = look2_s[DWIDTH-1:0];
endmodule

// File: tb/tb_wb_buffer.sv
// Directed self-checking bench for wb_buffer. Inputs change on the falling
// edge; outputs are checked at the falling edge or just after it.
module tb_wb_buffer;
  localparam int DEPTH  = 4;
  localparam int AWIDTH = 5;
  localparam int DWIDTH = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  wb_buffer_if #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

  wb_buffer #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock: through the rising edge, back to the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  int exp_aw [11] = '{10, 11, 12, 13, 20, 21, 22, 23, 24, 25, 26};
  int k;

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = 5'd0;
    bus.in_data  = 32'd0;
    bus.wr_grant = 1'b0;
    bus.ar1      = 5'd0;
    bus.ar2      = 5'd0;

    // reset state
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_reg_write", 32'(bus.reg_write), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_aw", 32'(bus.aw), 32'd0);
    check("rst_din", bus.din, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // 1) single push with grant: write appears one cycle after accept
    bus.wr_grant = 1'b1;
    push(5'd5, 32'hAAAA0001);
    check("t1_count_acc", 32'(bus.count), 32'd1);
    check("t1_rw_acc", 32'(bus.reg_write), 32'd0);
    step();
    check("t1_rw", 32'(bus.reg_write), 32'd1);
    check("t1_aw", 32'(bus.aw), 32'd5);
    check("t1_din", bus.din, 32'hAAAA0001);
    check("t1_count", 32'(bus.count), 32'd0);
    step();
    check("t1_rw_drop", 32'(bus.reg_write), 32'd0);
    check("t1_aw_hold", 32'(bus.aw), 32'd5);

    // 2) fill without grant, stalled 5th push, then ordered drain
    bus.wr_grant = 1'b0;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i));
    check("t2_count_full", 32'(bus.count), 32'd4);
    check("t2_ready_full", 32'(bus.in_ready), 32'd0);
    bus.ar1 = 5'd3;
    #1;
    check("t2_hit1", 32'(bus.hit1), 32'd1);
    check("t2_fwd1", bus.fwd1, 32'h103);
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd9;
    bus.in_data  = 32'h999;
    step();
    step();
    bus.ar2 = 5'd9;
    #1;
    check("t2_stall_count", 32'(bus.count), 32'd4);
    check("t2_stall_rw", 32'(bus.reg_write), 32'd0);
    check("t2_stall_hit2", 32'(bus.hit2), 32'd0);
    bus.in_valid = 1'b0;
    bus.wr_grant = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t2_rw", 32'(bus.reg_write), 32'd1);
      check("t2_aw", 32'(bus.aw), 32'(i));
      check("t2_din", bus.din, 32'h100 + 32'(i));
      check("t2_count", 32'(bus.count), 32'(4 - i));
    end
    step();
    check("t2_rw_end", 32'(bus.reg_write), 32'd0);

    // 3) duplicate destinations: youngest wins, output register is oldest
    bus.wr_grant = 1'b0;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    bus.ar1 = 5'd7;
    bus.ar2 = 5'd8;
    #1;
    check("t3_hit1", 32'(bus.hit1), 32'd1);
    check("t3_fwd1", bus.fwd1, 32'h22);
    check("t3_hit2", 32'(bus.hit2), 32'd0);
    check("t3_fwd2", bus.fwd2, 32'h0);
    bus.wr_grant = 1'b1;
    step();
    check("t3_din_a", bus.din, 32'h11);
    check("t3_fwd1_a", bus.fwd1, 32'h22);
    step();
    check("t3_din_b", bus.din, 32'h22);
    check("t3_count_b", 32'(bus.count), 32'd0);
    check("t3_hit1_outreg", 32'(bus.hit1), 32'd1);
    check("t3_fwd1_outreg", bus.fwd1, 32'h22);
    step();
    check("t3_hit1_gone", 32'(bus.hit1), 32'd0);
    check("t3_fwd1_gone", bus.fwd1, 32'h0);

    // 4) address 0 is accepted and dropped; lookup of 0 never hits
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd0;
    bus.in_data  = 32'hDEAD;
    #1;
    check("t4_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("t4_count", 32'(bus.count), 32'd0);
    check("t4_rw_a", 32'(bus.reg_write), 32'd0);
    step();
    check("t4_rw_b", 32'(bus.reg_write), 32'd0);
    bus.ar1 = 5'd0;
    #1;
    check("t4_hit1", 32'(bus.hit1), 32'd0);
    check("t4_fwd1", bus.fwd1, 32'h0);

    // 5) full with valid and grant: no accept on the full edge, then
    //    steady push/pop across pointer wrap
    bus.wr_grant = 1'b0;
    for (int i = 10; i <= 13; i++) push(5'(i), 32'h500 + 32'(i));
    k = 0;
    for (int c = 0; c < 8; c++) begin
      bus.wr_grant = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_addr  = 5'(20 + k);
      bus.in_data  = 32'h500 + 32'(20 + k);
      #1;
      check("t5_ready", 32'(bus.in_ready), (c == 0) ? 32'd0 : 32'd1);
      step();
      if (c > 0) k++;
      check("t5_rw", 32'(bus.reg_write), 32'd1);
      check("t5_aw", 32'(bus.aw), 32'(exp_aw[c]));
      check("t5_din", bus.din, 32'h500 + 32'(exp_aw[c]));
      check("t5_count", 32'(bus.count), 32'd3);
    end
    bus.in_valid = 1'b0;
    for (int c = 8; c < 11; c++) begin
      step();
      check("t5_drain_aw", 32'(bus.aw), 32'(exp_aw[c]));
      check("t5_drain_din", bus.din, 32'h500 + 32'(exp_aw[c]));
      check("t5_drain_count", 32'(bus.count), 32'(10 - c));
    end
    step();
    check("t5_rw_end", 32'(bus.reg_write), 32'd0);

    // 6) reset while a write is on the port and entries are pending
    bus.wr_grant = 1'b0;
    push(5'd3, 32'h33);
    push(5'd4, 32'h44);
    push(5'd5, 32'h55);
    bus.wr_grant = 1'b1;
    step();
    check("t6_rw_pre", 32'(bus.reg_write), 32'd1);
    check("t6_count_pre", 32'(bus.count), 32'd2);
    bus.wr_grant = 1'b0;
    bus.ar1 = 5'd4;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rw_rst", 32'(bus.reg_write), 32'd0);
    check("t6_count_rst", 32'(bus.count), 32'd0);
    check("t6_ready_rst", 32'(bus.in_ready), 32'd0);
    check("t6_hit1_rst", 32'(bus.hit1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_ready_rel", 32'(bus.in_ready), 32'd1);
    bus.wr_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_no_stale_rw", 32'(bus.reg_write), 32'd0);
      check("t6_no_stale_count", 32'(bus.count), 32'd0);
    end
    push(5'd6, 32'h66);
    step();
    check("t6_new_rw", 32'(bus.reg_write), 32'd1);
    check("t6_new_aw", 32'(bus.aw), 32'd6);
    check("t6_new_din", bus.din, 32'h66);
    step();
    check("t6_new_rw_end", 32'(bus.reg_write), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
